// File: rtl/mux_rr_sched_if.sv
// Requester-side bus of the round-robin mux scheduler: request/enable/release in,
// grant and mux select out.
interface mux_rr_sched_if #(
    parameter int N    = 16,
    parameter int SELW = 4
);
    // "release" is a reserved word in SystemVerilog, so the owner's done pulse is release_grant.
    logic            en;
    logic [N-1:0]    req;
    logic            release_grant;
    logic [SELW-1:0] sel;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic            timeout;

    modport master (
        output en, req, release_grant,
        input  sel, gnt, gnt_valid, timeout
    );

    modport slave (
        input  en, req, release_grant,
        output sel, gnt, gnt_valid, timeout
    );
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one 16:1 mux among N requesters, with a hold
// timeout and one dead (GAP) cycle between consecutive owners.
module mux_rr_sched #(
    parameter int N        = 16,
    parameter int SELW     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_sched_if.slave     bus
);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // With no timeout the hold counter simply saturates at all-ones.
    localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state, state_next;
    logic [SELW-1:0] ptr, ptr_next;
    logic [SELW-1:0] sel_q, sel_next;
    logic [N-1:0]    gnt_q, gnt_next;
    logic            gv_q, gv_next;
    logic            to_q, to_next;
    logic [HW-1:0]   hold, hold_next;

    logic [SELW-1:0] pick;
    logic            found;
    int              pos;
    logic            end_rel, end_drop, end_to, grant_end;

    // First set request at or above ptr, wrapping N-1 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) pos = pos - N;
            if (!found && bus.req[pos]) begin
                found = 1'b1;
                pick  = SELW'(pos);
            end
        end
    end

    assign end_rel   = bus.release_grant;
    assign end_drop  = ~bus.req[sel_q];
    assign end_to    = (MAX_HOLD != 0) && (hold == HOLD_SAT);
    assign grant_end = end_rel | end_drop | end_to;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            sel_q <= '0;
            gnt_q <= '0;
            gv_q  <= 1'b0;
            to_q  <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            sel_q <= sel_next;
            gnt_q <= gnt_next;
            gv_q  <= gv_next;
            to_q  <= to_next;
            hold  <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.en && found) state_next = GRANT;
            GRANT:   if (grant_end)       state_next = GAP;
            GAP:                          state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        ptr_next  = ptr;
        sel_next  = sel_q;
        gnt_next  = gnt_q;
        gv_next   = gv_q;
        to_next   = 1'b0;
        hold_next = hold;
        case (state)
            IDLE: begin
                if (bus.en && found) begin
                    gnt_next  = {{(N-1){1'b0}}, 1'b1} << pick;
                    sel_next  = pick;
                    gv_next   = 1'b1;
                    hold_next = HW'(1);
                end
            end
            GRANT: begin
                if (grant_end) begin
                    gnt_next = '0;
                    gv_next  = 1'b0;
                    ptr_next = (sel_q == SELW'(N - 1)) ? '0 : sel_q + 1'b1;
                    to_next  = end_to & ~end_rel & ~end_drop;
                end else if (hold != HOLD_SAT) begin
                    hold_next = hold + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // sel is never cleared on grant end, so the mux input stays put through GAP.
    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gv_q;
    assign bus.timeout   = to_q;
endmodule

// File: tb/tb_mux_rr_sched.sv
// Scoreboard bench for mux_rr_sched: a cycle-stamped reference model queues expected
// grants, grant ends and timeouts; a monitor pops and compares as the DUT shows them.
module tb_mux_rr_sched;
    localparam int N        = 16;
    localparam int SELW     = 4;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst_n;

    mux_rr_sched_if #(.N(N), .SELW(SELW)) bus ();

    mux_rr_sched #(.N(N), .SELW(SELW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int at;
    } grant_t;

    int     tests = 0;
    int     fails = 0;
    int     cyc   = 0;
    grant_t exp_grant[$];
    int     exp_end[$];
    int     exp_to[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one owner at a time; a new grant is allowed two edges after the
    // previous one ended; the search starts one past the previous owner.
    int m_owner, m_ptr, m_hold, m_end;
    bit m_rel, m_drop, m_exp;
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1;
                m_ptr   = 0;
                m_hold  = 0;
                m_end   = -10;
                exp_grant.delete();
                exp_end.delete();
                exp_to.delete();
            end else begin
                cyc++;
                if (m_owner >= 0) begin
                    m_rel  = bus.release_grant;
                    m_drop = !bus.req[m_owner];
                    m_exp  = (MAX_HOLD != 0) && (m_hold >= MAX_HOLD);
                    if (m_rel || m_drop || m_exp) begin
                        exp_end.push_back(cyc);
                        if (m_exp && !m_rel && !m_drop) exp_to.push_back(cyc);
                        m_ptr   = (m_owner + 1) % N;
                        m_owner = -1;
                        m_end   = cyc;
                    end else begin
                        m_hold++;
                    end
                end else if (cyc >= m_end + 2 && bus.en && bus.req != '0) begin
                    for (int k = 0; k < N; k++) begin
                        if (bus.req[(m_ptr + k) % N]) begin
                            m_owner = (m_ptr + k) % N;
                            break;
                        end
                    end
                    m_hold = 1;
                    exp_grant.push_back('{m_owner, cyc});
                end
            end
        end
    end

    // Monitor: compares every grant start, grant end and timeout pulse the DUT presents.
    bit     prev_gv;
    int     last_idx;
    grant_t g;
    initial begin
        prev_gv  = 1'b0;
        last_idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_gv = 1'b0;
            end else begin
                if (bus.gnt_valid && !prev_gv) begin
                    check("grant_queued", int'(exp_grant.size() > 0), 1);
                    if (exp_grant.size() > 0) begin
                        g = exp_grant.pop_front();
                        check("grant_idx", int'(bus.sel), g.idx);
                        check("grant_onehot", int'(bus.gnt), 1 << g.idx);
                        check("grant_cycle", cyc, g.at);
                    end
                    last_idx = int'(bus.sel);
                end
                if (!bus.gnt_valid && prev_gv) begin
                    check("end_queued", int'(exp_end.size() > 0), 1);
                    if (exp_end.size() > 0) check("end_cycle", cyc, exp_end.pop_front());
                    check("gap_sel_hold", int'(bus.sel), last_idx);
                    check("gap_gnt_zero", int'(bus.gnt), 0);
                end
                if (bus.timeout) begin
                    check("timeout_queued", int'(exp_to.size() > 0), 1);
                    if (exp_to.size() > 0) check("timeout_cycle", cyc, exp_to.pop_front());
                end
                prev_gv = bus.gnt_valid;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n             = 1'b0;
        bus.release_grant = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gv(input int budget, output int idx);
        int n = 0;
        while (!bus.gnt_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_grant", int'(bus.gnt_valid), 1);
        idx = int'(bus.sel);
    endtask

    task automatic pulse_release();
        bus.release_grant = 1'b1;
        @(negedge clk);
        bus.release_grant = 1'b0;
    endtask

    task automatic idle_out(input int n);
        bus.req           = '0;
        bus.release_grant = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int idx, n;
    initial begin
        rst_n             = 1'b0;
        bus.en            = 1'b1;
        bus.req           = '1;
        bus.release_grant = 1'b0;

        // Reset with all requests pending, then the first grant one edge later.
        repeat (3) @(negedge clk);
        check("rst_gnt", int'(bus.gnt), 0);
        check("rst_gnt_valid", int'(bus.gnt_valid), 0);
        check("rst_sel", int'(bus.sel), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t1_first_gnt", int'(bus.gnt), 1);
        check("t1_first_sel", int'(bus.sel), 0);
        check("t1_first_valid", int'(bus.gnt_valid), 1);
        idle_out(4);

        // Two requesters alternate with released grants.
        bus.req = 16'h8001;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_gv(20, idx);
            check("t2_order", idx, (k % 2 == 1) ? 15 : 0);
            pulse_release();
        end
        idle_out(4);

        // Held request runs into the hold limit and is granted again afterwards.
        bus.req = 16'h0010;
        do_reset();
        wait_gv(20, idx);
        check("t3_first", idx, 4);
        n = 0;
        while (bus.gnt_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("t3_hold_len", n, MAX_HOLD);
        check("t3_timeout", int'(bus.timeout), 1);
        wait_gv(20, idx);
        check("t3_regrant", idx, 4);
        idle_out(6);

        // Park ptr at 14, then wrap to 0 and 1; release coincides with the request change.
        bus.req = 16'h2000;
        do_reset();
        wait_gv(20, idx);
        check("t4_setup", idx, 13);
        bus.req = 16'h0003;
        pulse_release();
        wait_gv(20, idx);
        check("t4_wrap0", idx, 0);
        pulse_release();
        wait_gv(20, idx);
        check("t4_wrap1", idx, 1);
        pulse_release();
        idle_out(4);

        // Asynchronous reset in the middle of a grant.
        bus.req = '1;
        do_reset();
        wait_gv(20, idx);
        pulse_release();
        wait_gv(20, idx);
        check("t5_pre_idx", idx, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt", int'(bus.gnt), 0);
        check("t5_async_valid", int'(bus.gnt_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_gv(20, idx);
        check("t5_restart", idx, 0);
        idle_out(4);

        // Enable drops during a grant: the grant finishes, nothing new until re-enabled.
        bus.req = 16'h0008;
        do_reset();
        wait_gv(20, idx);
        check("t6_first", idx, 3);
        bus.en  = 1'b0;
        bus.req = '1;
        repeat (3) @(negedge clk);
        check("t6_grant_survives", int'(bus.gnt_valid), 1);
        pulse_release();
        n = 0;
        repeat (12) begin
            if (bus.gnt_valid) n++;
            @(negedge clk);
        end
        check("t6_no_grant_en0", n, 0);
        bus.en = 1'b1;
        wait_gv(20, idx);
        check("t6_resume", idx, 4);
        idle_out(4);

        // Randomised traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) bus.req = N'($urandom & $urandom);
            bus.release_grant = ($urandom_range(0, 9) == 0);
            @(negedge clk);
        end
        bus.en = 1'b1;
        idle_out(8);
        check("drain_grants", exp_grant.size(), 0);
        check("drain_ends", exp_end.size(), 0);
        check("drain_timeouts", exp_to.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
